// File: rtl/arm_id_pkg.sv
// Shared constants and bundles for the ARM-subset ID stage.
// Includes ALU commands, opcodes, modes, condition codes and flag indices.
package arm_id_pkg;

  localparam logic [3:0] EXE_NOP = 4'b0000;
  localparam logic [3:0] EXE_MOV = 4'b0001;
  localparam logic [3:0] EXE_ADD = 4'b0010;
  localparam logic [3:0] EXE_ADC = 4'b0011;
  localparam logic [3:0] EXE_SUB = 4'b0100;
  localparam logic [3:0] EXE_SBC = 4'b0101;
  localparam logic [3:0] EXE_AND = 4'b0110;
  localparam logic [3:0] EXE_ORR = 4'b0111;
  localparam logic [3:0] EXE_EOR = 4'b1000;
  localparam logic [3:0] EXE_MVN = 4'b1001;

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_EOR = 4'b0001;
  localparam logic [3:0] OP_SUB = 4'b0010;
  localparam logic [3:0] OP_ADD = 4'b0100;
  localparam logic [3:0] OP_ADC = 4'b0101;
  localparam logic [3:0] OP_SBC = 4'b0110;
  localparam logic [3:0] OP_TST = 4'b1000;
  localparam logic [3:0] OP_CMP = 4'b1010;
  localparam logic [3:0] OP_ORR = 4'b1100;
  localparam logic [3:0] OP_MOV = 4'b1101;
  localparam logic [3:0] OP_MVN = 4'b1111;

  localparam logic [1:0] MODE_DP  = 2'b00;
  localparam logic [1:0] MODE_MEM = 2'b01;
  localparam logic [1:0] MODE_BR  = 2'b10;

  localparam logic [3:0] CC_EQ = 4'b0000;
  localparam logic [3:0] CC_NE = 4'b0001;
  localparam logic [3:0] CC_CS = 4'b0010;
  localparam logic [3:0] CC_CC = 4'b0011;
  localparam logic [3:0] CC_MI = 4'b0100;
  localparam logic [3:0] CC_PL = 4'b0101;
  localparam logic [3:0] CC_VS = 4'b0110;
  localparam logic [3:0] CC_VC = 4'b0111;
  localparam logic [3:0] CC_HI = 4'b1000;
  localparam logic [3:0] CC_LS = 4'b1001;
  localparam logic [3:0] CC_GE = 4'b1010;
  localparam logic [3:0] CC_LT = 4'b1011;
  localparam logic [3:0] CC_GT = 4'b1100;
  localparam logic [3:0] CC_LE = 4'b1101;
  localparam logic [3:0] CC_AL = 4'b1110;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  typedef struct packed {
    logic [3:0] exe_cmd;
    logic       mem_read;
    logic       mem_write;
    logic       wb_enable;
    logic       b;
    logic       update_sr;
  } ctrl_t;

  localparam ctrl_t CTRL_NONE = '0;

endpackage

// File: rtl/arm_cond_check.sv
// Condition evaluator: Instruction[31:28] against {N,Z,C,V}.
// Pure combinational; code 1111 never passes.
module arm_cond_check
  import arm_id_pkg::*;
(
  input  logic [3:0] cond,
  input  logic [3:0] sr,
  output logic       cond_pass
);

  logic n, z, c, v;

  assign n = sr[FLAG_N];
  assign z = sr[FLAG_Z];
  assign c = sr[FLAG_C];
  assign v = sr[FLAG_V];

  always_comb begin
    cond_pass = 1'b0;
    unique case (cond)
      CC_EQ:   cond_pass = z;
      CC_NE:   cond_pass = !z;
      CC_CS:   cond_pass = c;
      CC_CC:   cond_pass = !c;
      CC_MI:   cond_pass = n;
      CC_PL:   cond_pass = !n;
      CC_VS:   cond_pass = v;
      CC_VC:   cond_pass = !v;
      CC_HI:   cond_pass = c && !z;
      CC_LS:   cond_pass = !c || z;
      CC_GE:   cond_pass = (n == v);
      CC_LT:   cond_pass = (n != v);
      CC_GT:   cond_pass = !z && (n == v);
      CC_LE:   cond_pass = z || (n != v);
      CC_AL:   cond_pass = 1'b1;
      default: cond_pass = 1'b0;
    endcase
  end

endmodule

// File: rtl/arm_id_decode_core.sv
// ARM-subset ID decode core: control decoder, condition check, register file.
// Define RF_WRITE_BYPASS_EN to forward the WB write onto same-cycle reads.
module arm_id_decode_core
  import arm_id_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int NUM_REGS = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        mode,
  input  logic [3:0]        op_code,
  input  logic              s_in,
  input  logic [3:0]        cond,
  input  logic [3:0]        sr,
  input  logic [3:0]        src1,
  input  logic [3:0]        src2,
  input  logic [3:0]        dest_wb,
  input  logic [DATA_W-1:0] result_wb,
  input  logic              write_back_en,
  output logic [3:0]        exe_cmd,
  output logic              mem_read,
  output logic              mem_write,
  output logic              wb_enable,
  output logic              b,
  output logic              update_sr,
  output logic              cond_pass,
  output logic [DATA_W-1:0] reg1,
  output logic [DATA_W-1:0] reg2
);

  ctrl_t ctrl;

  always_comb begin
    ctrl = CTRL_NONE;
    unique case (1'b1)
      mode == MODE_DP: begin
        ctrl.update_sr = s_in;
        ctrl.wb_enable = 1'b1;
        unique case (op_code)
          OP_MOV: ctrl.exe_cmd = EXE_MOV;
          OP_MVN: ctrl.exe_cmd = EXE_MVN;
          OP_ADD: ctrl.exe_cmd = EXE_ADD;
          OP_ADC: ctrl.exe_cmd = EXE_ADC;
          OP_SUB: ctrl.exe_cmd = EXE_SUB;
          OP_SBC: ctrl.exe_cmd = EXE_SBC;
          OP_AND: ctrl.exe_cmd = EXE_AND;
          OP_ORR: ctrl.exe_cmd = EXE_ORR;
          OP_EOR: ctrl.exe_cmd = EXE_EOR;
          OP_CMP: begin
            ctrl.exe_cmd   = EXE_SUB;
            ctrl.wb_enable = 1'b0;
          end
          OP_TST: begin
            ctrl.exe_cmd   = EXE_AND;
            ctrl.wb_enable = 1'b0;
          end
          default: ctrl = CTRL_NONE;
        endcase
      end
      mode == MODE_MEM: begin
        ctrl.exe_cmd   = EXE_ADD;
        ctrl.mem_read  = s_in;
        ctrl.wb_enable = s_in;
        ctrl.mem_write = !s_in;
      end
      mode == MODE_BR: ctrl.b = 1'b1;
      default: ctrl = CTRL_NONE;
    endcase
  end

  assign exe_cmd   = ctrl.exe_cmd;
  assign mem_read  = ctrl.mem_read;
  assign mem_write = ctrl.mem_write;
  assign wb_enable = ctrl.wb_enable;
  assign b         = ctrl.b;
  assign update_sr = ctrl.update_sr;

  arm_cond_check u_cond (
    .cond      (cond),
    .sr        (sr),
    .cond_pass (cond_pass)
  );

  logic [DATA_W-1:0] rf [NUM_REGS];
  logic              wr_ok;

  assign wr_ok = write_back_en && (int'(dest_wb) < NUM_REGS);

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++)
        rf[i] <= DATA_W'(i);
    end else if (wr_ok) begin
      rf[dest_wb] <= result_wb;
    end
  end

  logic [DATA_W-1:0] rd1, rd2;

  assign rd1 = (int'(src1) < NUM_REGS) ? rf[src1] : '0;
  assign rd2 = (int'(src2) < NUM_REGS) ? rf[src2] : '0;

`ifdef RF_WRITE_BYPASS_EN
  assign reg1 = (wr_ok && dest_wb == src1) ? result_wb : rd1;
  assign reg2 = (wr_ok && dest_wb == src2) ? result_wb : rd2;
`else
  assign reg1 = rd1;
  assign reg2 = rd2;
`endif

endmodule

// File: tb/tb_arm_id_decode_core.sv
// Directed bench for arm_id_decode_core.
// Covers reset image, writes, decode, conditions and bypass timing.
module tb_arm_id_decode_core;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  mode;
  logic [3:0]  op_code;
  logic        s_in;
  logic [3:0]  cond;
  logic [3:0]  sr;
  logic [3:0]  src1;
  logic [3:0]  src2;
  logic [3:0]  dest_wb;
  logic [31:0] result_wb;
  logic        write_back_en;
  logic [3:0]  exe_cmd;
  logic        mem_read;
  logic        mem_write;
  logic        wb_enable;
  logic        b;
  logic        update_sr;
  logic        cond_pass;
  logic [31:0] reg1;
  logic [31:0] reg2;

  int total  = 0;
  int passed = 0;

  always #5 clk = ~clk;

  arm_id_decode_core dut (
    .clk           (clk),
    .rst           (rst),
    .mode          (mode),
    .op_code       (op_code),
    .s_in          (s_in),
    .cond          (cond),
    .sr            (sr),
    .src1          (src1),
    .src2          (src2),
    .dest_wb       (dest_wb),
    .result_wb     (result_wb),
    .write_back_en (write_back_en),
    .exe_cmd       (exe_cmd),
    .mem_read      (mem_read),
    .mem_write     (mem_write),
    .wb_enable     (wb_enable),
    .b             (b),
    .update_sr     (update_sr),
    .cond_pass     (cond_pass),
    .reg1          (reg1),
    .reg2          (reg2)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: got %h want %h", tag, obs, exp);
  endtask

  // {exe_cmd, mem_read, mem_write, wb_enable, b, update_sr}
  function automatic logic [31:0] ctl();
    return {23'd0, exe_cmd, mem_read, mem_write, wb_enable, b, update_sr};
  endfunction

  task automatic dec(input string tag, input logic [1:0] m,
                     input logic [3:0] op, input logic s,
                     input logic [8:0] exp);
    mode = m; op_code = op; s_in = s;
    #1;
    chk(tag, ctl(), {23'd0, exp});
  endtask

  task automatic cc(input string tag, input logic [3:0] f,
                    input logic [3:0] c, input logic exp);
    sr = f; cond = c;
    #1;
    chk(tag, {31'd0, cond_pass}, {31'd0, exp});
  endtask

  task automatic edge_step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; mode = 2'b11; op_code = '0; s_in = 1'b0;
    cond = 4'hE; sr = '0; src1 = '0; src2 = '0;
    write_back_en = 1'b0; dest_wb = '0; result_wb = '0;

    // Reset edge with a competing write: reset must win.
    write_back_en = 1'b1; dest_wb = 4'd3; result_wb = 32'hAAAA5555;
    edge_step();
    rst = 1'b0; write_back_en = 1'b0;

    for (int i = 0; i < 16; i++) begin
      src1 = 4'(i); src2 = 4'(15 - i);
      #1;
      chk("rst_r1", reg1, (i < 15) ? 32'(i) : 32'd0);
      chk("rst_r2", reg2, (i > 0) ? 32'(15 - i) : 32'd0);
    end

    // Same-cycle read of the address being written.
    write_back_en = 1'b1; dest_wb = 4'd5;
    result_wb = 32'h12345678; src2 = 4'd5; src1 = 4'd5;
    #1;
`ifdef RF_WRITE_BYPASS_EN
    chk("byp_pre", reg2, 32'h12345678);
`else
    chk("byp_pre", reg2, 32'd5);
`endif
    edge_step();
    chk("byp_post", reg2, 32'h12345678);

    dest_wb = 4'd3; result_wb = 32'hDEADBEEF; src1 = 4'd3;
    edge_step();
    chk("wr_r3", reg1, 32'hDEADBEEF);

    dest_wb = 4'd15; result_wb = 32'hFFFFFFFF;
    edge_step();
    write_back_en = 1'b0;
    src1 = 4'd15; src2 = 4'd14;
    #1;
    chk("wr15_r15", reg1, 32'd0);
    chk("wr15_r14", reg2, 32'd14);
    src1 = 4'd3; src2 = 4'd0;
    #1;
    chk("wr15_r3", reg1, 32'hDEADBEEF);
    chk("wr15_r0", reg2, 32'd0);

    rst = 1'b1; write_back_en = 1'b1;
    dest_wb = 4'd3; result_wb = 32'h00000055;
    edge_step();
    rst = 1'b0; write_back_en = 1'b0;
    src1 = 4'd3; src2 = 4'd5;
    #1;
    chk("rstwr_r3", reg1, 32'd3);
    chk("rstwr_r5", reg2, 32'd5);

    dec("add", 2'b00, 4'b0100, 1'b1, 9'b0010_0_0_1_0_1);
    dec("sub", 2'b00, 4'b0010, 1'b1, 9'b0100_0_0_1_0_1);
    dec("cmp", 2'b00, 4'b1010, 1'b1, 9'b0100_0_0_0_0_1);
    dec("tst", 2'b00, 4'b1000, 1'b1, 9'b0110_0_0_0_0_1);
    dec("mvn", 2'b00, 4'b1111, 1'b1, 9'b1001_0_0_1_0_1);
    dec("mov", 2'b00, 4'b1101, 1'b0, 9'b0001_0_0_1_0_0);
    dec("eor", 2'b00, 4'b0001, 1'b0, 9'b1000_0_0_1_0_0);
    dec("bad", 2'b00, 4'b0011, 1'b1, 9'b0000_0_0_0_0_0);
    dec("ldr", 2'b01, 4'b0100, 1'b1, 9'b0010_1_0_1_0_0);
    dec("str", 2'b01, 4'b0100, 1'b0, 9'b0010_0_1_0_0_0);
    dec("br",  2'b10, 4'b0100, 1'b1, 9'b0000_0_0_0_1_0);
    dec("m11", 2'b11, 4'b0100, 1'b1, 9'b0000_0_0_0_0_0);

    cc("eq_z",  4'b0100, 4'b0000, 1'b1);
    cc("ne_z",  4'b0100, 4'b0001, 1'b0);
    cc("ls_z",  4'b0100, 4'b1001, 1'b1);
    cc("gt_z",  4'b0100, 4'b1100, 1'b0);
    cc("ge_nv", 4'b1001, 4'b1010, 1'b1);
    cc("lt_nv", 4'b1001, 4'b1011, 1'b0);
    cc("gt_nv", 4'b1001, 4'b1100, 1'b1);
    cc("hi_c",  4'b0010, 4'b1000, 1'b1);
    cc("le_n",  4'b1000, 4'b1101, 1'b1);
    cc("mi_n",  4'b1000, 4'b0100, 1'b1);
    cc("vc_v",  4'b0001, 4'b0111, 1'b0);
    cc("al",    4'b0000, 4'b1110, 1'b1);
    cc("nv",    4'b1111, 4'b1111, 1'b0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/arm_id_decode_core.md
Name: arm_id_decode_core

Overview:
- Combinational decode core of the ARM-subset Instruction Decode stage. Contains three functions: a control decoder, a condition evaluator and a 15-entry register file.
- The control decoder maps mode, opcode and S bit to execute and memory control signals.
- The condition evaluator checks Instruction[31:28] against the status flags.
- The register file has two combinational read ports and one synchronous write port fed by Write-Back.
- The parent ID stage adds hazard/condition gating, the src2 mux and the pipeline register.

Parameters:
- DATA_W, 32, register and data width.
- NUM_REGS, 15, architectural registers R0..R14.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- mode  in  2  Instruction[27:26].
- op_code  in  4  Instruction[24:21].
- s_in  in  1  Instruction[20].
- cond  in  4  Instruction[31:28].
- sr  in  4  status flags {N,Z,C,V}: bit3 = N, bit0 = V.
- src1  in  4  read address A (Rn).
- src2  in  4  read address B (Rm or Rd).
- dest_wb  in  4  write address.
- result_wb  in  32  write data.
- write_back_en  in  1  write enable.
- exe_cmd  out  4  ALU command.
- mem_read  out  1  load.
- mem_write  out  1  store.
- wb_enable  out  1  result writes a register.
- b  out  1  branch.
- update_sr  out  1  instruction updates flags.
- cond_pass  out  1  condition satisfied.
- reg1  out  32  contents at src1.
- reg2  out  32  contents at src2.

Behaviour:
- Control outputs, cond_pass, reg1 and reg2 are purely combinational, with zero latency. There is no reset value for them; they follow the inputs.
- mode 00 (data processing): update_sr = s_in; mem_read = 0; mem_write = 0; b = 0. Opcode to exe_cmd and wb_enable:
  - MOV 1101 -> 0001, wb 1
  - MVN 1111 -> 1001, wb 1
  - ADD 0100 -> 0010, wb 1
  - ADC 0101 -> 0011, wb 1
  - SUB 0010 -> 0100, wb 1
  - SBC 0110 -> 0101, wb 1
  - AND 0000 -> 0110, wb 1
  - ORR 1100 -> 0111, wb 1
  - EOR 0001 -> 1000, wb 1
  - CMP 1010 -> 0100, wb 0
  - TST 1000 -> 0110, wb 0
  - any other opcode -> exe_cmd 0000, all enables 0.
- mode 01 (memory): exe_cmd = 0010 (address add); update_sr = 0; b = 0.
  - s_in = 1 (LDR): mem_read = 1, wb_enable = 1, mem_write = 0.
  - s_in = 0 (STR): mem_write = 1, mem_read = 0, wb_enable = 0.
- mode 10 (branch): b = 1; all other outputs 0; exe_cmd = 0000.
- mode 11: all outputs 0.
- cond_pass by cond value:
  - 0000 EQ: Z
  - 0001 NE: !Z
  - 0010 CS: C
  - 0011 CC: !C
  - 0100 MI: N
  - 0101 PL: !N
  - 0110 VS: V
  - 0111 VC: !V
  - 1000 HI: C & !Z
  - 1001 LS: !C | Z
  - 1010 GE: N == V
  - 1011 LT: N != V
  - 1100 GT: !Z & (N == V)
  - 1101 LE: Z | (N != V)
  - 1110 AL: 1
  - 1111: 0
- Register file write: on the rising clk edge, if write_back_en is high and dest_wb < 15, then R[dest_wb] <= result_wb.
  - Writes to address 15 are ignored.
  - Reads of address 15 return 0.
- Register file reset: on a rising edge with rst = 1, every R[i] <= i (zero-extended). Reset has priority over a simultaneous write.
- Without the bypass feature, a read of the address being written returns the old value until after the edge. Both ports may read the same address.

Optional Feature:
- Macro RF_WRITE_BYPASS_EN.
- When defined: if write_back_en = 1, dest_wb = src1 (or src2) and dest_wb != 15, then reg1 (or reg2) returns result_wb combinationally in the same cycle.
- When undefined: reads always return stored contents.

Decomposition:
- Shared package arm_id_pkg holds:
  - EXE_CMD constants (EXE_MOV, EXE_ADD, ...).
  - Data-processing opcode constants.
  - Mode constants.
  - Condition-code constants.
  - Flag bit indices N = 3, Z = 2, C = 1, V = 0.
- One natural sub-module: arm_cond_check (pure combinational cond/sr -> cond_pass). The control decoder and register file stay inline.

Test Plan:
- Reset: assert rst for one edge; read addresses 0..14 on both ports -> reg value equals index; address 15 -> 0.
- Write/read: write_back_en = 1, dest_wb = 3, result_wb = 0xDEADBEEF, one edge -> reg1 with src1 = 3 returns 0xDEADBEEF. dest_wb = 15 -> no register changes. Write during rst -> value stays 3.
- Decode sweep: mode 00, opcodes ADD / SUB / CMP / TST / MVN with s_in = 1 -> exe_cmd 0010 / 0100 / 0100 / 0110 / 1001; wb 1 / 1 / 0 / 0 / 1; update_sr 1.
- Memory and branch: mode 01 s_in = 1 -> exe_cmd 0010, mem_read = 1, wb = 1. mode 01 s_in = 0 -> mem_write = 1, wb = 0. mode 10 -> b = 1, rest 0.
- Conditions: sr = 4'b0100 (Z) -> EQ 1, NE 0, LS 1, GT 0. sr = 4'b1001 (N, V) -> GE 1, LT 0, GT 1. AL 1. cond 1111 -> 0.
- Bypass (RF_WRITE_BYPASS_EN): write 0x12345678 to R5 with src2 = 5 -> reg2 = 0x12345678 before the edge. Without the macro -> reg2 = 5 before the edge.
